// File: rtl/onehot_strobe_decoder_if.sv
// onehot_strobe_decoder_if: index handshake plus strobe outputs; err_cnt exists only with ONEHOT_DEC_ERR_CNT_EN
interface onehot_strobe_decoder_if #(
   parameter int W = 3,
   parameter int N = 8
);
   logic         in_valid;
   logic         in_ready;
   logic [W-1:0] in_idx;
   logic [N-1:0] out_onehot;
   logic         out_valid;
   logic         busy;
   logic         err;
`ifdef ONEHOT_DEC_ERR_CNT_EN
   logic [7:0]   err_cnt;
   modport master (output in_valid, in_idx, input in_ready, out_onehot, out_valid, busy, err, err_cnt);
   modport slave  (input in_valid, in_idx, output in_ready, out_onehot, out_valid, busy, err, err_cnt);
`else
   modport master (output in_valid, in_idx, input in_ready, out_onehot, out_valid, busy, err);
   modport slave  (input in_valid, in_idx, output in_ready, out_onehot, out_valid, busy, err);
`endif
endinterface

// File: rtl/onehot_strobe_decoder.sv
// onehot_strobe_decoder: 2-entry FIFO of binary indices driven out as HOLD-cycle one-hot strobes; ONEHOT_DEC_ERR_CNT_EN adds err_cnt
module onehot_strobe_decoder #(
   parameter int W    = 3,
   parameter int N    = 8,
   parameter int HOLD = 1
) (
   input logic clk,
   input logic rst_n,
   onehot_strobe_decoder_if.slave bus
);
   localparam int CW = $clog2(HOLD) + 1;
   typedef enum logic {IDLE, DRIVE} state_t;
   state_t        state_q, state_d;
   logic [W-1:0]  mem_q [2];
   logic [W-1:0]  mem_d [2];
   logic          rd_q, rd_d, wr_q, wr_d;
   logic [1:0]    count_q, count_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic [N-1:0]  oh_q, oh_d;
   logic          valid_q, valid_d, err_q, err_d;
   logic          accept, in_range, push, pop;
`ifdef ONEHOT_DEC_ERR_CNT_EN
   logic [7:0]    ecnt_q, ecnt_d;
   assign bus.err_cnt = ecnt_q;
`endif
   assign bus.in_ready   = rst_n && count_q != 2'd2;
   assign in_range       = (N == 2 ** W) || (32'(bus.in_idx) < N);
   assign accept         = bus.in_valid && bus.in_ready;
   assign push           = accept && in_range;
   assign bus.out_onehot = oh_q;
   assign bus.out_valid  = valid_q;
   assign bus.busy       = valid_q || count_q != 2'd0;
   assign bus.err        = err_q;
   // next state: pop a new word when idle or when the current strobe ends, otherwise count down or go idle
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      oh_d    = oh_q;
      valid_d = valid_q;
      mem_d   = mem_q;
      rd_d    = rd_q;
      wr_d    = wr_q;
      pop     = 1'b0;
      if (count_q != 2'd0 && (state_q == IDLE || cnt_q == '0)) begin
         pop     = 1'b1;
         oh_d    = N'(1) << mem_q[rd_q];
         valid_d = 1'b1;
         cnt_d   = CW'(HOLD - 1);
         state_d = DRIVE;
         rd_d    = ~rd_q;
      end else if (state_q == DRIVE && cnt_q != '0) begin
         cnt_d = cnt_q - 1'b1;
      end else if (state_q == DRIVE) begin
         oh_d    = '0;
         valid_d = 1'b0;
         state_d = IDLE;
      end
      if (push) begin
         mem_d[wr_q] = bus.in_idx;
         wr_d        = ~wr_q;
      end
      count_d = count_q + {1'b0, push} - {1'b0, pop};
      err_d   = accept && !in_range;
`ifdef ONEHOT_DEC_ERR_CNT_EN
      ecnt_d  = (err_d && ecnt_q != 8'hFF) ? ecnt_q + 8'd1 : ecnt_q;
`endif
   end
   // state registers with synchronous active-low clear
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         oh_q    <= '0;
         valid_q <= 1'b0;
         err_q   <= 1'b0;
         mem_q   <= '{default: '0};
         rd_q    <= 1'b0;
         wr_q    <= 1'b0;
         count_q <= 2'd0;
`ifdef ONEHOT_DEC_ERR_CNT_EN
         ecnt_q  <= 8'd0;
`endif
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         oh_q    <= oh_d;
         valid_q <= valid_d;
         err_q   <= err_d;
         mem_q   <= mem_d;
         rd_q    <= rd_d;
         wr_q    <= wr_d;
         count_q <= count_d;
`ifdef ONEHOT_DEC_ERR_CNT_EN
         ecnt_q  <= ecnt_d;
`endif
      end
   end
endmodule
